// File: rtl/regfile_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_pkg
// Description : Shared widths and the write-back entry type used by the
//               write-back arbiter, its result FIFO and its bus interface.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_writeback_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // One buffered long-latency result: destination register plus value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage : regfile_writeback_pkg
`default_nettype wire

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_if
// Description : Bundle of every write-back signal except clk/rst.
//               slave  : the write-back block (regfile_writeback)
//               master : execute/memory/decode side driving results/queries
//               Groups: ALU result, long-latency result (valid/ready),
//               issue notification, two RAW queries, register-file write
//               port and FIFO occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_writeback_if
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0]     alu_data;

    logic                  lc_valid;
    logic                  lc_ready;
    logic [REG_ADDR_W-1:0] lc_rd;
    logic [DATA_W-1:0]     lc_data;

    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_rd;

    logic [REG_ADDR_W-1:0] q_addr0;
    logic [REG_ADDR_W-1:0] q_addr1;
    logic                  q_busy0;
    logic                  q_busy1;

    logic                  rf_wen;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;

    logic [CNT_W-1:0]      fifo_count;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lc_valid, lc_rd, lc_data,
        output lc_ready,
        input  iss_valid, iss_rd,
        input  q_addr0, q_addr1,
        output q_busy0, q_busy1,
        output rf_wen, rf_waddr, rf_wdata,
        output fifo_count
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lc_valid, lc_rd, lc_data,
        input  lc_ready,
        output iss_valid, iss_rd,
        output q_addr0, q_addr1,
        input  q_busy0, q_busy1,
        input  rf_wen, rf_waddr, rf_wdata,
        input  fifo_count
    );

endinterface : regfile_writeback_if
`default_nettype wire

// File: rtl/regfile_writeback_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : In-order synchronous FIFO of wb_entry_t. Occupancy, full and
//               empty are all registered, so an entry pushed into an empty
//               FIFO becomes visible at the head one cycle later.
//               Ports: i_push/i_entry (write), i_pop/o_head (read),
//               o_full, o_empty, o_count.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire wb_entry_t              i_entry,
    input  wire logic                   i_pop,
    output      wb_entry_t              o_head,
    output      logic                   o_full,
    output      logic                   o_empty,
    output      logic [$clog2(DEPTH):0] o_count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    wb_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_push;
    logic                 w_pop;

    // Requests beyond capacity/occupancy are ignored rather than corrupting state.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Storage needs no reset: pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;   // DEPTH is a power of 2: natural wrap
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : Write-back arbiter and pending-write scoreboard in front of
//               the register file's single write port. ALU results always
//               win; buffered long-latency results drain when the ALU is idle.
//               A 32-bit pending map, set on issue and cleared when the FIFO
//               result reaches the register file, answers decode RAW queries.
//               Ports: clk, rst, bus (regfile_writeback_if.slave).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input wire logic            clk,
    input wire logic            rst,
    regfile_writeback_if.slave  bus
);
    localparam int c_NUM_REGS = 1 << REG_ADDR_W;

    wb_entry_t             w_lc_entry;
    wb_entry_t             w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [$clog2(DEPTH):0] w_count;

    logic                  r_rf_wen;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0]     r_rf_wdata;
    logic                  r_src_fifo;      // current rf write originated in the FIFO
    logic [c_NUM_REGS-1:0] r_pending;
    logic [c_NUM_REGS-1:0] w_pending_next;

    assign w_lc_entry = '{rd: bus.lc_rd, data: bus.lc_data};
    assign w_push     = bus.lc_valid && bus.lc_ready;
    // The FIFO drains only in cycles the ALU leaves the write port free.
    assign w_pop      = !bus.alu_valid && !w_empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_lc_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Output registers and source flag. With nothing selected the address
    // and data simply hold; only the enable matters to the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_src_fifo <= 1'b0;
        end else if (bus.alu_valid) begin
            r_rf_wen   <= (bus.alu_rd != '0);
            r_rf_waddr <= bus.alu_rd;
            r_rf_wdata <= bus.alu_data;
            r_src_fifo <= 1'b0;
        end else if (w_pop) begin
            r_rf_wen   <= (w_head.rd != '0);
            r_rf_waddr <= w_head.rd;
            r_rf_wdata <= w_head.data;
            r_src_fifo <= 1'b1;
        end else begin
            r_rf_wen   <= 1'b0;
            r_src_fifo <= 1'b0;
        end
    end

    // Clear is applied before set so a same-cycle re-issue keeps the bit.
    always_comb begin
        w_pending_next = r_pending;
        if (r_rf_wen && r_src_fifo) begin
            w_pending_next[r_rf_waddr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != '0)) begin
            w_pending_next[bus.iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Bit 0 can never be set, so x0 queries always read not-busy.
    assign bus.q_busy0    = r_pending[bus.q_addr0];
    assign bus.q_busy1    = r_pending[bus.q_addr1];

    assign bus.lc_ready   = !w_full && !rst;
    assign bus.rf_wen     = r_rf_wen;
    assign bus.rf_waddr   = r_rf_waddr;
    assign bus.rf_wdata   = r_rf_wdata;
    assign bus.fifo_count = w_count;

endmodule : regfile_writeback
`default_nettype wire
